mem_map_checker: RTL and testbench

- Synthesizable, parametrised successor to the testbench's ad-hoc memory-map check, cycle watchdog and end-of-test detection.
- Sits beside the core on the data bus and samples accepted transactions against NUM_REGIONS programmable address windows.
- Counts and captures violations, enforces a cycle budget, and latches the end-of-test verdict into a status code.
- Usable in simulation and on-chip during LBIST/functional test-mode runs.

---
 rtl/mem_map_checker.sv | 187 ++++++++++++++++++
 tb/tb_mem_map_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_map_checker.sv
// mem_map_checker: samples accepted data-bus transactions against a set of
// programmable address windows, counts and captures out-of-map accesses,
// runs an optional cycle watchdog and latches the end-of-test verdict.
// Optional macro MEM_MAP_READ_CHECK_EN: also flag accepted reads that fall
// outside every window (default: writes only).
module mem_map_checker #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE  = {NUM_REGIONS{32'h0020_0000}},
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT = {NUM_REGIONS{32'h0024_0000}},
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned CYC_WIDTH   = 32,
   parameter int unsigned MAX_CYCLES  = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  data_req_i,
   input  logic                  data_gnt_i,
   input  logic                  data_we_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic                  tests_passed_i,
   input  logic                  tests_failed_i,
   input  logic                  exit_valid_i,
   input  logic [31:0]           exit_value_i,
   output logic                  viol_o,
   output logic [CNT_WIDTH-1:0]  viol_cnt_o,
   output logic                  first_viol_valid_o,
   output logic [ADDR_WIDTH-1:0] first_viol_addr_o,
   output logic [CYC_WIDTH-1:0]  cycle_cnt_o,
   output logic [31:0]           exit_value_o,
   output logic [2:0]            status_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   localparam logic [2:0] STAT_RUN       = 3'd0;
   localparam logic [2:0] STAT_PASS      = 3'd1;
   localparam logic [2:0] STAT_FAIL      = 3'd2;
   localparam logic [2:0] STAT_EXIT_OK   = 3'd3;
   localparam logic [2:0] STAT_EXIT_FAIL = 3'd4;
   localparam logic [2:0] STAT_TIMEOUT   = 3'd5;

   // Watchdog fires when the counter sits on the last allowed RUN cycle.
   localparam bit                   WD_EN   = (MAX_CYCLES != 0);
   localparam logic [CYC_WIDTH-1:0] WD_LAST = CYC_WIDTH'(MAX_CYCLES - 1);

   state_e                  state_q, state_d;
   logic                    viol_q, viol_d;
   logic [CNT_WIDTH-1:0]    viol_cnt_q, viol_cnt_d;
   logic                    first_valid_q, first_valid_d;
   logic [ADDR_WIDTH-1:0]   first_addr_q, first_addr_d;
   logic [CYC_WIDTH-1:0]    cycle_cnt_q, cycle_cnt_d;
   logic [31:0]             exit_value_q, exit_value_d;
   logic [2:0]              status_q, status_d;
   logic                    done_q, done_d;

   logic [NUM_REGIONS-1:0]  region_hit;
   logic                    accepted;
   logic                    checked;
   logic                    viol_event;
   logic                    wd_hit;

   // One comparator pair per window; a window with base > limit never hits.
   generate
      for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
         localparam logic [ADDR_WIDTH-1:0] BASE  = REGION_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
         localparam logic [ADDR_WIDTH-1:0] LIMIT = REGION_LIMIT[gi*ADDR_WIDTH +: ADDR_WIDTH];
         localparam bit                    ENA   = (BASE <= LIMIT);
         assign region_hit[gi] = ENA && (data_addr_i >= BASE) && (data_addr_i <= LIMIT);
      end
   endgenerate

   assign accepted = (state_q == ST_RUN) && data_req_i && data_gnt_i;

`ifdef MEM_MAP_READ_CHECK_EN
   assign checked = accepted;
`else
   assign checked = accepted && data_we_i;
`endif

   assign viol_event = checked && !(|region_hit);
   assign wd_hit     = WD_EN && (cycle_cnt_q == WD_LAST);

   // Next-state and datapath: violation bookkeeping, end-event priority, watchdog.
   always_comb begin
      state_d       = state_q;
      viol_d        = 1'b0;
      viol_cnt_d    = viol_cnt_q;
      first_valid_d = first_valid_q;
      first_addr_d  = first_addr_q;
      cycle_cnt_d   = cycle_cnt_q;
      exit_value_d  = exit_value_q;
      status_d      = status_q;
      done_d        = done_q;

      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A violation on the same cycle as an end event still counts.
            if (viol_event) begin
               viol_d = 1'b1;
               if (viol_cnt_q != {CNT_WIDTH{1'b1}}) begin
                  viol_cnt_d = viol_cnt_q + CNT_WIDTH'(1);
               end
               if (!first_valid_q) begin
                  first_valid_d = 1'b1;
                  first_addr_d  = data_addr_i;
               end
            end
            if (exit_valid_i) begin
               exit_value_d = exit_value_i;
            end
            // The counter only advances on cycles that stay in RUN, so a
            // timeout leaves it on MAX_CYCLES-1.
            if (tests_failed_i) begin
               state_d  = ST_DONE;
               status_d = STAT_FAIL;
               done_d   = 1'b1;
            end else if (exit_valid_i) begin
               state_d  = ST_DONE;
               status_d = (exit_value_i != 32'd0) ? STAT_EXIT_FAIL : STAT_EXIT_OK;
               done_d   = 1'b1;
            end else if (tests_passed_i) begin
               state_d  = ST_DONE;
               status_d = STAT_PASS;
               done_d   = 1'b1;
            end else if (wd_hit) begin
               state_d  = ST_TIMEOUT;
               status_d = STAT_TIMEOUT;
               done_d   = 1'b1;
            end else if (cycle_cnt_q != {CYC_WIDTH{1'b1}}) begin
               cycle_cnt_d = cycle_cnt_q + CYC_WIDTH'(1);
            end
         end
         default: begin
            // Terminal: everything holds until reset.
            status_d = (state_q == ST_TIMEOUT) ? STAT_TIMEOUT : status_q;
         end
      endcase
   end

   // State and output registers with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         viol_q        <= 1'b0;
         viol_cnt_q    <= '0;
         first_valid_q <= 1'b0;
         first_addr_q  <= '0;
         cycle_cnt_q   <= '0;
         exit_value_q  <= '0;
         status_q      <= STAT_RUN;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         viol_q        <= viol_d;
         viol_cnt_q    <= viol_cnt_d;
         first_valid_q <= first_valid_d;
         first_addr_q  <= first_addr_d;
         cycle_cnt_q   <= cycle_cnt_d;
         exit_value_q  <= exit_value_d;
         status_q      <= status_d;
         done_q        <= done_d;
      end
   end

   assign viol_o             = viol_q;
   assign viol_cnt_o         = viol_cnt_q;
   assign first_viol_valid_o = first_valid_q;
   assign first_viol_addr_o  = first_addr_q;
   assign cycle_cnt_o        = cycle_cnt_q;
   assign exit_value_o       = exit_value_q;
   assign status_o           = status_q;
   assign done_o             = done_q;

endmodule

// File: tb/tb_mem_map_checker.sv
// Directed bench for mem_map_checker: out-of-map capture, saturation,
// end-event priority, watchdog timeout and reset clearing.
module tb_mem_map_checker;

   localparam int unsigned AW = 32;
   localparam int unsigned NR = 4;
   localparam int unsigned CW = 2;
   localparam int unsigned YW = 32;
   // r0 0x0020_0000..0x0024_0000, r1 disabled (base > limit),
   // r2 0x0040_0000..0x0040_00FF, r3 single word 0x8000_0000.
   localparam logic [NR*AW-1:0] BASES  = {32'h8000_0000, 32'h0040_0000, 32'h0010_0000, 32'h0020_0000};
   localparam logic [NR*AW-1:0] LIMITS = {32'h8000_0000, 32'h0040_00FF, 32'h0000_0000, 32'h0024_0000};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          req = 1'b0, gnt = 1'b0, we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          passed = 1'b0, failed = 1'b0, exit_valid = 1'b0;
   logic [31:0]   exit_value = '0;
   logic          viol, first_valid, done;
   logic [CW-1:0] viol_cnt;
   logic [AW-1:0] first_addr;
   logic [YW-1:0] cycle_cnt;
   logic [31:0]   exit_out;
   logic [2:0]    status;

   int n_checks = 0;
   int n_errors = 0;

   mem_map_checker #(
      .ADDR_WIDTH(AW), .NUM_REGIONS(NR), .REGION_BASE(BASES), .REGION_LIMIT(LIMITS),
      .CNT_WIDTH(CW), .CYC_WIDTH(YW), .MAX_CYCLES(100)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable),
      .data_req_i(req), .data_gnt_i(gnt), .data_we_i(we), .data_addr_i(addr),
      .tests_passed_i(passed), .tests_failed_i(failed),
      .exit_valid_i(exit_valid), .exit_value_i(exit_value),
      .viol_o(viol), .viol_cnt_o(viol_cnt),
      .first_viol_valid_o(first_valid), .first_viol_addr_o(first_addr),
      .cycle_cnt_o(cycle_cnt), .exit_value_o(exit_out),
      .status_o(status), .done_o(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      enable = 1'b0; req = 1'b0; gnt = 1'b0; we = 1'b0; addr = '0;
      passed = 1'b0; failed = 1'b0; exit_valid = 1'b0; exit_value = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic start();
      enable = 1'b1;
      tick();
      enable = 1'b0;
   endtask

   task automatic bus(input logic [AW-1:0] a, input logic w, input logic r, input logic g);
      addr = a; we = w; req = r; gnt = g;
      tick();
      req = 1'b0; gnt = 1'b0; we = 1'b0;
   endtask

   logic [CW-1:0] exp_cnt;
   int ticks;

   initial begin
      // Reset state
      do_reset();
      check("rst_viol", 64'(viol), 64'd0);
      check("rst_cnt", 64'(viol_cnt), 64'd0);
      check("rst_status", 64'(status), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cycle", 64'(cycle_cnt), 64'd0);

      // Single out-of-map write (also hits the disabled window's range)
      start();
      check("run_cycle0", 64'(cycle_cnt), 64'd0);
      bus(32'h0010_0000, 1'b1, 1'b1, 1'b1);
      check("t1_viol", 64'(viol), 64'd1);
      check("t1_cnt", 64'(viol_cnt), 64'd1);
      check("t1_addr", 64'(first_addr), 64'h0010_0000);
      check("t1_valid", 64'(first_valid), 64'd1);
      tick();
      check("t1_pulse_end", 64'(viol), 64'd0);

      // Boundaries and capture-once; reset drops prior capture
      do_reset();
      check("t2_rst_valid", 64'(first_valid), 64'd0);
      start();
      bus(32'h0020_0000, 1'b1, 1'b1, 1'b1);
      check("t2_base_ok", 64'(viol), 64'd0);
      bus(32'h0024_0000, 1'b1, 1'b1, 1'b1);
      check("t2_limit_ok", 64'(viol), 64'd0);
      bus(32'h0024_0004, 1'b1, 1'b1, 1'b1);
      bus(32'h0030_0000, 1'b1, 1'b1, 1'b1);
      check("t2_cnt", 64'(viol_cnt), 64'd2);
      check("t2_first", 64'(first_addr), 64'h0024_0004);
      check("t2_cycle", 64'(cycle_cnt), 64'd4);
      bus(32'h0030_0000, 1'b0, 1'b1, 1'b1);
`ifdef MEM_MAP_READ_CHECK_EN
      exp_cnt = 2'd3;
`else
      exp_cnt = 2'd2;
`endif
      check("t2_read", 64'(viol_cnt), 64'(exp_cnt));
      do_reset();
      start();
      bus(32'h8000_0000, 1'b1, 1'b1, 1'b1);
      check("t2_r3_ok", 64'(viol), 64'd0);
      bus(32'h0040_00FF, 1'b1, 1'b1, 1'b1);
      check("t2_r2_ok", 64'(viol), 64'd0);
      bus(32'h0040_0100, 1'b1, 1'b1, 1'b1);
      check("t2_r2_over", 64'(viol), 64'd1);

      // No grant / IDLE: never checked
      do_reset();
      bus(32'h0010_0000, 1'b1, 1'b1, 1'b1);
      check("t3_idle_viol", 64'(viol), 64'd0);
      check("t3_idle_cnt", 64'(viol_cnt), 64'd0);
      start();
      bus(32'h0010_0000, 1'b1, 1'b1, 1'b0);
      check("t3_nognt_viol", 64'(viol), 64'd0);
      check("t3_nognt_cnt", 64'(viol_cnt), 64'd0);

      // Saturation at 3 with a 2-bit counter
      do_reset();
      start();
      for (int i = 0; i < 5; i++) begin
         bus(32'h0050_0000 + 32'(i * 4), 1'b1, 1'b1, 1'b1);
      end
      check("t4_sat", 64'(viol_cnt), 64'd3);
      check("t4_first", 64'(first_addr), 64'h0050_0000);

      // failed + exit(0) + violation together: fail wins, violation counted
      do_reset();
      start();
      failed = 1'b1; exit_valid = 1'b1; exit_value = 32'd0;
      bus(32'h0010_0000, 1'b1, 1'b1, 1'b1);
      clear_inputs();
      check("t5_status", 64'(status), 64'd2);
      check("t5_done", 64'(done), 64'd1);
      check("t5_viol_cnt", 64'(viol_cnt), 64'd1);
      passed = 1'b1; enable = 1'b1;
      bus(32'h0010_0004, 1'b1, 1'b1, 1'b1);
      clear_inputs();
      check("t5_term_status", 64'(status), 64'd2);
      check("t5_term_cnt", 64'(viol_cnt), 64'd1);
      check("t5_term_cycle", 64'(cycle_cnt), 64'd0);

      // exit with nonzero value; later exits ignored
      do_reset();
      start();
      tick();
      tick();
      exit_valid = 1'b1; exit_value = 32'd7;
      tick();
      exit_value = 32'd9;
      tick();
      clear_inputs();
      check("t6_status", 64'(status), 64'd4);
      check("t6_exit", 64'(exit_out), 64'd7);
      check("t6_cycle", 64'(cycle_cnt), 64'd2);

      // exit(0) beats passed; passed alone
      do_reset();
      start();
      exit_valid = 1'b1; passed = 1'b1;
      tick();
      clear_inputs();
      check("t7_exit_ok", 64'(status), 64'd3);
      do_reset();
      start();
      passed = 1'b1;
      tick();
      clear_inputs();
      check("t7_pass", 64'(status), 64'd1);

      // Watchdog: timeout after 100 RUN cycles, counter holds 99
      do_reset();
      start();
      ticks = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick();
         ticks++;
      end
      check("t8_ticks", 64'(ticks), 64'd100);
      check("t8_status", 64'(status), 64'd5);
      check("t8_cycle", 64'(cycle_cnt), 64'd99);
      tick();
      tick();
      check("t8_hold", 64'(cycle_cnt), 64'd99);
      rst = 1'b1;
      tick();
      check("t8_rst_status", 64'(status), 64'd0);
      check("t8_rst_done", 64'(done), 64'd0);
      check("t8_rst_cycle", 64'(cycle_cnt), 64'd0);
      rst = 1'b0;
      tick();
      tick();
      check("t8_idle_cycle", 64'(cycle_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
